line_fill_unit: RTL and testbench

//  Miss-handling stage directly upstream of each cache way. On a miss it writes back the dirty victim line,

---
 rtl/line_fill_if.sv | 37 +++
 rtl/line_fill_unit.sv | 77 +++++++
 tb/tb_line_fill_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/line_fill_if.sv
// line_fill_if: request, victim, memory-beat and allocate signals of the line fill unit.
interface line_fill_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int BLOCK_SIZE    = 32,
    parameter int ADDRESS_WIDTH = 32
);
    localparam int WPB = BLOCK_SIZE / (DATA_WIDTH / 8);
    logic                      req_valid;
    logic                      req_ready;
    logic [ADDRESS_WIDTH-1:0]  req_address;
    logic                      victim_dirty;
    logic [ADDRESS_WIDTH-1:0]  victim_address;
    logic [WPB*DATA_WIDTH-1:0] victim_line;
    logic                      mem_req_valid;
    logic                      mem_req_ready;
    logic                      mem_req_write;
    logic [ADDRESS_WIDTH-1:0]  mem_req_address;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic                      mem_rvalid;
    logic [DATA_WIDTH-1:0]     mem_rdata;
    logic                      allocate;
    logic [ADDRESS_WIDTH-1:0]  line_address;
    logic [WPB*DATA_WIDTH-1:0] fetched_line;
    logic                      busy;
    modport slave (
        input  req_valid, req_address, victim_dirty, victim_address, victim_line,
               mem_req_ready, mem_rvalid, mem_rdata,
        output req_ready, mem_req_valid, mem_req_write, mem_req_address, mem_wdata,
               allocate, line_address, fetched_line, busy
    );
    modport master (
        output req_valid, req_address, victim_dirty, victim_address, victim_line,
               mem_req_ready, mem_rvalid, mem_rdata,
        input  req_ready, mem_req_valid, mem_req_write, mem_req_address, mem_wdata,
               allocate, line_address, fetched_line, busy
    );
endinterface

// File: rtl/line_fill_unit.sv
// line_fill_unit: writes back a dirty victim line, fetches the missing line word by word, then allocates it.
module line_fill_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int BLOCK_SIZE    = 32,
    parameter int ADDRESS_WIDTH = 32
) (
    input logic        clk,
    input logic        reset_n,
    line_fill_if.slave bus
);
    localparam int WPB          = BLOCK_SIZE / (DATA_WIDTH / 8);
    localparam int OFFSET_WIDTH = $clog2(WPB);
    localparam int CW           = OFFSET_WIDTH + 1;
    typedef enum logic [1:0] {IDLE, WRITEBACK, READ, ALLOC} state_t;
    state_t                   state, state_nx;
    logic [CW-1:0]            wcnt, icnt, rcnt;
    logic [ADDRESS_WIDTH-1:0] miss_base, victim_base;
    logic [DATA_WIDTH-1:0]    victim_w [WPB];
    logic [DATA_WIDTH-1:0]    line_w [WPB];
    logic                     accept, issuing, wbeat, rbeat, rcap;
    assign accept  = state == IDLE && bus.req_valid;
    assign issuing = state == READ && icnt < CW'(WPB);
    assign wbeat   = state == WRITEBACK && bus.mem_req_ready;
    assign rbeat   = issuing && bus.mem_req_ready;
    assign rcap    = state == READ && bus.mem_rvalid;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wcnt        <= '0;
            icnt        <= '0;
            rcnt        <= '0;
            miss_base   <= '0;
            victim_base <= '0;
            for (int i = 0; i < WPB; i++) begin
                victim_w[i] <= '0;
                line_w[i]   <= '0;
            end
        end else if (accept) begin
            wcnt        <= '0;
            icnt        <= '0;
            rcnt        <= '0;
            miss_base   <= {bus.req_address[ADDRESS_WIDTH-1:OFFSET_WIDTH], OFFSET_WIDTH'(0)};
            victim_base <= {bus.victim_address[ADDRESS_WIDTH-1:OFFSET_WIDTH], OFFSET_WIDTH'(0)};
            for (int i = 0; i < WPB; i++) victim_w[i] <= bus.victim_line[i*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            if (wbeat) wcnt <= wcnt + CW'(1);
            if (rbeat) icnt <= icnt + CW'(1);
            // Responses are counted separately from issues so they may lag or coincide.
            if (rcap) begin
                line_w[rcnt[OFFSET_WIDTH-1:0]] <= bus.mem_rdata;
                rcnt <= rcnt + CW'(1);
            end
        end
    end
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:      if (bus.req_valid) state_nx = bus.victim_dirty ? WRITEBACK : READ;
            WRITEBACK: if (wbeat && wcnt == CW'(WPB - 1)) state_nx = READ;
            READ:      if (rcap && rcnt == CW'(WPB - 1)) state_nx = ALLOC;
            default:   state_nx = IDLE;
        endcase
        bus.req_ready       = state == IDLE;
        bus.busy            = state != IDLE;
        bus.mem_req_valid   = state == WRITEBACK || issuing;
        bus.mem_req_write   = state == WRITEBACK;
        bus.mem_req_address = state == WRITEBACK ? victim_base + ADDRESS_WIDTH'(wcnt) :
                              issuing ? miss_base + ADDRESS_WIDTH'(icnt) : '0;
        bus.mem_wdata       = state == WRITEBACK ? victim_w[wcnt[OFFSET_WIDTH-1:0]] : '0;
        bus.allocate        = state == ALLOC;
        bus.line_address    = miss_base;
        for (int i = 0; i < WPB; i++) bus.fetched_line[i*DATA_WIDTH +: DATA_WIDTH] = line_w[i];
    end
endmodule

// File: tb/tb_line_fill_unit.sv
// tb_line_fill_unit: randomized fills against a queue-based reference of the expected memory traffic and line.
module tb_line_fill_unit;
    logic clk = 0;
    logic reset_n = 0;
    line_fill_if bus ();
    line_fill_unit dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));
    always #5 clk = ~clk;
    int n_checks = 0, n_err = 0;
    int cyc = 0, acc_cnt = 0, alloc_cnt = 0, rcvd = 0, acc_cyc = 0, alloc_cyc = 0, stall_cnt = 0;
    bit ideal = 1, stall_wb2 = 0, a0_mode = 0, open_txn = 0, stalled = 0, prev_alloc = 0;
    logic [31:0] salt = 0, held_addr = 0, held_data = 0, exp_base = 0;
    logic [255:0] exp_line = 0;
    logic [63:0] wr_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] pend[$];
    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a0_mode ? 32'hA0 + {29'b0, a[2:0]} : (a * 32'h9E3779B1) ^ salt;
    endfunction
    // Memory responder plus scoreboard: drive at negedge, observe 1 time unit later.
    always @(negedge clk) begin : mon
        logic [63:0] w;
        logic [31:0] a;
        bit same;
        same = 0;
        bus.mem_req_ready = 1'b1;
        if (stall_wb2 && bus.mem_req_valid && bus.mem_req_write && bus.mem_req_address[2:0] == 3'd2 && stall_cnt < 3) begin
            bus.mem_req_ready = 1'b0;
            stall_cnt++;
        end else if (!ideal) bus.mem_req_ready = $urandom_range(0, 3) != 0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        if (pend.size() != 0 && (ideal || $urandom_range(0, 2) != 0)) begin
            a = pend.pop_front();
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = mdata(a);
            rcvd++;
        end else if (!ideal && pend.size() == 0 && bus.mem_req_valid && !bus.mem_req_write && bus.mem_req_ready && $urandom_range(0, 1) == 1) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = mdata(bus.mem_req_address);
            rcvd++;
            same = 1;
        end
        #1;
        cyc++;
        if (!reset_n) begin
            wr_q.delete();
            rd_q.delete();
            pend.delete();
            open_txn = 0;
            stalled = 0;
            prev_alloc = 0;
        end else begin
            check("busy", bus.busy, !bus.req_ready);
            if (stalled) begin
                check("stall_valid", bus.mem_req_valid, 1);
                check("stall_addr", bus.mem_req_address, held_addr);
                check("stall_wdata", bus.mem_wdata, held_data);
            end
            stalled   = bus.mem_req_valid && !bus.mem_req_ready;
            held_addr = bus.mem_req_address;
            held_data = bus.mem_wdata;
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                if (bus.mem_req_write) begin
                    check("wr_expected", wr_q.size() != 0, 1);
                    if (wr_q.size() != 0) begin
                        w = wr_q.pop_front();
                        check("wr_addr", bus.mem_req_address, w[63:32]);
                        check("wr_data", bus.mem_wdata, w[31:0]);
                    end
                end else begin
                    check("rd_after_wb", wr_q.size() == 0, 1);
                    check("rd_expected", rd_q.size() != 0, 1);
                    if (rd_q.size() != 0) check("rd_addr", bus.mem_req_address, rd_q.pop_front());
                    if (!same) pend.push_back(bus.mem_req_address);
                end
            end
            if (bus.allocate) begin
                check("alloc_open", open_txn, 1);
                check("alloc_single", prev_alloc, 0);
                check("line_address", bus.line_address, exp_base);
                check("fetched_line", bus.fetched_line, exp_line);
                check("alloc_drained", wr_q.size() + rd_q.size() + pend.size(), 0);
                open_txn = 0;
                alloc_cnt++;
                alloc_cyc = cyc;
            end
            prev_alloc = bus.allocate;
            if (bus.req_valid && bus.req_ready) begin
                exp_base = {bus.req_address[31:3], 3'b0};
                a = {bus.victim_address[31:3], 3'b0};
                wr_q.delete();
                rd_q.delete();
                for (int i = 0; i < 8; i++) begin
                    if (bus.victim_dirty) wr_q.push_back({a + i, bus.victim_line[i*32 +: 32]});
                    rd_q.push_back(exp_base + i);
                    exp_line[i*32 +: 32] = mdata(exp_base + i);
                end
                open_txn = 1;
                acc_cnt++;
                acc_cyc = cyc;
                rcvd = 0;
                stall_cnt = 0;
            end
        end
    end
    task automatic drive_req(input logic [31:0] addr, input bit dirty, input logic [31:0] vaddr, input logic [255:0] vline);
        @(negedge clk);
        bus.req_valid      = 1'b1;
        bus.req_address    = addr;
        bus.victim_dirty   = dirty;
        bus.victim_address = vaddr;
        bus.victim_line    = vline;
    endtask
    task automatic wait_accept(input bit hold, input logic [31:0] addr2);
        int c0;
        c0 = acc_cnt;
        for (int k = 0; k < 400 && acc_cnt == c0; k++) @(posedge clk);
        check("accept_seen", acc_cnt != c0, 1);
        @(negedge clk);
        if (hold) begin
            bus.req_address  = addr2;
            bus.victim_dirty = 1'b0;
        end else bus.req_valid = 1'b0;
    endtask
    task automatic run_fill(input bit hold, input logic [31:0] addr2);
        int a0;
        a0 = alloc_cnt;
        wait_accept(hold, addr2);
        for (int k = 0; k < 2000 && alloc_cnt == a0; k++) @(posedge clk);
        check("alloc_seen", alloc_cnt != a0, 1);
    endtask
    function automatic logic [255:0] seq_line(input logic [31:0] b);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = b + i;
        return l;
    endfunction
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int a0;
        bus.req_valid = 0;
        bus.req_address = 0;
        bus.victim_dirty = 0;
        bus.victim_address = 0;
        bus.victim_line = 0;
        salt = $urandom;
        repeat (3) @(negedge clk);
        #2;
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_mem_valid", bus.mem_req_valid, 0);
        check("rst_mem_write", bus.mem_req_write, 0);
        check("rst_mem_addr", bus.mem_req_address, 0);
        check("rst_wdata", bus.mem_wdata, 0);
        check("rst_allocate", bus.allocate, 0);
        check("rst_line_addr", bus.line_address, 0);
        check("rst_line", bus.fetched_line, 0);
        @(negedge clk);
        reset_n = 1;
        a0_mode = 1;
        drive_req(32'h105, 0, 32'h0, 256'h0);
        run_fill(0, 0);
        check("lat_clean", alloc_cyc - acc_cyc, 10);
        repeat (5) @(negedge clk);
        #2;
        check("line_addr_hold", bus.line_address, 32'h100);
        check("line_hold", bus.fetched_line, seq_line(32'hA0));
        drive_req(32'h105, 1, 32'h203, seq_line(32'hD0));
        run_fill(0, 0);
        check("lat_dirty", alloc_cyc - acc_cyc, 18);
        stall_wb2 = 1;
        drive_req(32'h105, 1, 32'h200, seq_line(32'hD0));
        run_fill(0, 0);
        stall_wb2 = 0;
        check("stall_cycles", stall_cnt, 3);
        check("lat_stall", alloc_cyc - acc_cyc, 21);
        drive_req(32'h400, 0, 32'h0, 256'h0);
        run_fill(1, 32'h5A3);
        check("hold_first_addr", bus.line_address, 32'h400);
        run_fill(0, 0);
        check("hold_second_addr", bus.line_address, 32'h5A0);
        ideal = 0;
        a0_mode = 0;
        for (int t = 0; t < 25; t++) begin
            drive_req($urandom, $urandom_range(0, 1) == 1, $urandom,
                      {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
            run_fill(0, 0);
        end
        ideal = 1;
        drive_req(32'h300, 0, 32'h0, 256'h0);
        wait_accept(0, 0);
        for (int k = 0; k < 100 && rcvd < 4; k++) @(posedge clk);
        check("rst_mid_words", rcvd >= 4, 1);
        @(negedge clk);
        reset_n = 0;
        a0 = alloc_cnt;
        #2;
        check("abort_mem_valid", bus.mem_req_valid, 0);
        check("abort_allocate", bus.allocate, 0);
        check("abort_line", bus.fetched_line, 0);
        check("abort_req_ready", bus.req_ready, 1);
        repeat (2) @(negedge clk);
        reset_n = 1;
        repeat (15) @(posedge clk);
        check("abort_no_alloc", alloc_cnt, a0);
        check("abort_line_after", bus.fetched_line, 0);
        drive_req(32'h777, 1, 32'h640, seq_line(32'h55));
        run_fill(0, 0);
        check("recover_lat", alloc_cyc - acc_cyc, 18);
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
